// File: rtl/mp1000_cart_ctrl.sv
// rtl/mp1000_cart_ctrl.sv - MP1000 cartridge loader and CPU read arbiter for a single-port cart RAM
module mp1000_cart_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int CART_INDEX = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W:0]   cart_size,
    output logic              cart_valid,
    output logic              cart_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH, S_RUN} state_t;

    state_t            state_q, state_d;
    logic              hold_q, hold_d, valid_q, valid_d, ovf_q, ovf_d;
    logic              we_q, we_d, ack_q, ack_d, rd1_q, rd1_d, rd2_q, rd2_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mask_q, mask_d, fill_mask;
    logic [7:0]        wdata_q, wdata_d, rdata_q, rdata_d;
    logic [ADDR_W:0]   size_q, size_d;
    logic [ADDR_W-1:0] size_m1;
    logic [25:0]       addr_p1;
    logic              cart_dl, in_range;
    logic              unused_idx;

    assign unused_idx = ^ioctl_index[7:6];
    assign cart_dl    = ioctl_download && (ioctl_index[5:0] == 6'(CART_INDEX));
    assign in_range   = ~|ioctl_addr[24:ADDR_W];
    assign addr_p1    = {1'b0, ioctl_addr} + 26'd1;
    assign size_m1    = ADDR_W'(size_q - 1'b1);

    // Smear size-1 rightwards to get the next power of two minus one.
    always_comb begin
        fill_mask = size_m1;
        for (int i = ADDR_W - 2; i >= 0; i--) begin
            fill_mask[i] = fill_mask[i] | fill_mask[i+1];
        end
        if (size_q == '0) fill_mask = '1;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        size_d  = size_q;
        ovf_d   = ovf_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        rd1_d   = 1'b0;
        rd2_d   = 1'b0;
        case (state_q)
            S_IDLE: state_d = cart_dl ? S_LOAD : S_RUN;
            S_LOAD: begin
                if (ioctl_wr) begin
                    if (in_range) begin
                        we_d    = 1'b1;
                        addr_d  = ioctl_addr[ADDR_W-1:0];
                        wdata_d = ioctl_dout;
                        if (addr_p1 > 26'(size_q)) size_d = addr_p1[ADDR_W:0];
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (!ioctl_download) state_d = S_FINISH;
            end
            S_FINISH: begin
                valid_d = (size_q != '0);
                mask_d  = fill_mask;
                state_d = S_RUN;
            end
            default: begin
                if (!cart_dl) begin
                    rd2_d = rd1_q;
                    if (rd2_q) begin
                        ack_d   = 1'b1;
                        rdata_d = valid_q ? mem_rdata : 8'hFF;
                    end
                    if (cpu_req && !rd1_q && !rd2_q && !ack_q) begin
                        rd1_d  = 1'b1;
                        addr_d = cpu_addr & mask_q;
                    end
                end
            end
        endcase
        // Load entry from IDLE or RUN drops any read in flight via the defaults above.
        if (cart_dl && (state_q == S_IDLE || state_q == S_RUN)) begin
            state_d = S_LOAD;
            valid_d = 1'b0;
            size_d  = '0;
            ovf_d   = 1'b0;
        end
        hold_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hold_q  <= 1'b1;
            valid_q <= 1'b0;
            size_q  <= '0;
            ovf_q   <= 1'b0;
            mask_q  <= '1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            rd1_q   <= 1'b0;
            rd2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            size_q  <= size_d;
            ovf_q   <= ovf_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    assign cpu_rdata     = rdata_q;
    assign cpu_ack       = ack_q;
    assign cpu_hold      = hold_q;
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign cart_size     = size_q;
    assign cart_valid    = valid_q;
    assign cart_overflow = ovf_q;

endmodule

// File: tb/tb_mp1000_cart_ctrl.sv
// tb/tb_mp1000_cart_ctrl.sv - directed self-checking bench for mp1000_cart_ctrl
module tb_mp1000_cart_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        cpu_req;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_hold;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [14:0] cart_size;
    logic        cart_valid;
    logic        cart_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    logic [7:0] ram [0:16383];

    always #5 clk_sys = ~clk_sys;

    mp1000_cart_ctrl #(.ADDR_W(14), .CART_INDEX(1)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_hold(cpu_hold),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cart_size(cart_size), .cart_valid(cart_valid), .cart_overflow(cart_overflow)
    );

    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk_sys) if (mem_we === 1'b1) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // lat = edges from acceptance (first edge after request) to the ack edge.
    task automatic cpu_read(input logic [13:0] a, output logic [7:0] d, output int lat,
                            output logic [13:0] ma);
        @(negedge clk_sys);
        cpu_req = 1'b1;
        cpu_addr = a;
        lat = -1;
        d = 8'h00;
        ma = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_sys);
            if (i == 1) ma = mem_addr;
            if (cpu_ack) begin
                lat = i - 1;
                d = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    logic [7:0]  d;
    logic [13:0] ma;
    int          lat, we0, errs, acks;

    initial begin
        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; cpu_req = 1'b0; cpu_addr = '0;
        repeat (2) @(negedge clk_sys);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_valid", cart_valid, 0);
        chk("rst_size", cart_size, 0);
        chk("rst_ovf", cart_overflow, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        reset = 1'b0;
        chk("hold_idle", cpu_hold, 1);
        @(negedge clk_sys);
        chk("hold_run", cpu_hold, 0);

        cpu_read(14'h0123, d, lat, ma);
        chk("nocart_rdata", d, 8'hFF);
        chk("nocart_lat", lat, 2);
        chk("nocart_valid", cart_valid, 0);

        // 4 KiB image, byte value = low address byte, one write per cycle
        we0 = we_cnt; errs = 0;
        ioctl_download = 1'b1; ioctl_index = 8'd1;
        @(negedge clk_sys);
        chk("load_hold", cpu_hold, 1);
        for (int i = 0; i < 4096; i++) begin
            if (i > 0 && (mem_we !== 1'b1 || mem_addr !== 14'(i - 1) || mem_wdata !== 8'(i - 1))) errs++;
            if (cpu_hold !== 1'b1) errs++;
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i);
            @(negedge clk_sys);
        end
        if (mem_we !== 1'b1 || mem_addr !== 14'hFFF || mem_wdata !== 8'hFF) errs++;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        if (mem_we !== 1'b0) errs++;
        chk("load_we_seq", errs, 0);
        chk("load_size", cart_size, 4096);
        chk("load_valid_low", cart_valid, 0);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("finish_hold", cpu_hold, 1);
        @(negedge clk_sys);
        chk("post_hold", cpu_hold, 0);
        chk("post_valid", cart_valid, 1);
        chk("post_size", cart_size, 4096);
        chk("post_we_count", we_cnt - we0, 4096);

        cpu_read(14'h1005, d, lat, ma);
        chk("mirror_maddr_1005", ma, 14'h0005);
        chk("mirror_rdata_1005", d, 8'h05);
        chk("mirror_lat", lat, 2);
        cpu_read(14'h3FFF, d, lat, ma);
        chk("mirror_maddr_3fff", ma, 14'h0FFF);
        chk("mirror_rdata_3fff", d, 8'hFF);

        // BIOS download must be invisible to the cartridge path
        we0 = we_cnt;
        @(negedge clk_sys);
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'hAA;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        cpu_read(14'h0010, d, lat, ma);
        chk("bios_rdata", d, 8'h10);
        chk("bios_hold", cpu_hold, 0);
        chk("bios_we", we_cnt - we0, 0);
        chk("bios_size", cart_size, 4096);
        ioctl_download = 1'b0;

        // Last in-range byte plus one byte past the window
        we0 = we_cnt;
        @(negedge clk_sys);
        ioctl_download = 1'b1; ioctl_index = 8'd1;
        @(negedge clk_sys);
        chk("ovf_clear_on_entry", cart_overflow, 0);
        ioctl_wr = 1'b1; ioctl_addr = 25'h3FFF; ioctl_dout = 8'h77;
        @(negedge clk_sys);
        chk("ovf_we_3fff", mem_we, 1);
        chk("ovf_maddr_3fff", mem_addr, 14'h3FFF);
        ioctl_addr = 25'h4000; ioctl_dout = 8'h88;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("ovf_no_we_4000", mem_we, 0);
        chk("ovf_flag", cart_overflow, 1);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("ovf_size", cart_size, 16384);
        chk("ovf_valid", cart_valid, 1);
        chk("ovf_flag_kept", cart_overflow, 1);
        chk("ovf_we_count", we_cnt - we0, 1);
        cpu_read(14'h3FFF, d, lat, ma);
        chk("full_rdata_3fff", d, 8'h77);
        cpu_read(14'h0005, d, lat, ma);
        chk("full_maddr_0005", ma, 14'h0005);
        chk("full_rdata_0005", d, 8'h05);

        // Cart download while a read is outstanding
        @(negedge clk_sys);
        cpu_req = 1'b1; cpu_addr = 14'h0005;
        @(negedge clk_sys);
        ioctl_download = 1'b1; ioctl_index = 8'd1;
        @(negedge clk_sys);
        chk("abandon_hold", cpu_hold, 1);
        acks = 0;
        if (cpu_ack) acks++;
        repeat (4) begin
            @(negedge clk_sys);
            if (cpu_ack) acks++;
        end
        chk("abandon_no_ack", acks, 0);
        cpu_req = 1'b0;

        // Reset arriving mid-LOAD while a write is on the RAM port
        ioctl_wr = 1'b1; ioctl_addr = 25'h20; ioctl_dout = 8'h5A;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("pre_rst_we", mem_we, 1);
        chk("pre_rst_size", cart_size, 33);
        #1 reset = 1'b1;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_size", cart_size, 0);
        chk("midrst_valid", cart_valid, 0);
        chk("midrst_hold", cpu_hold, 1);
        chk("midrst_maddr", mem_addr, 0);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
